pe_traffic_gen: RTL and testbench
=================================

PE_TRAFFIC_GEN -- requirements
Module: pe_traffic_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload bits per flit (tx_data/rx_data are DATA_W+1 wide, MSB = last flag).
REQ-002 SHALL have parameter DEST_W, default 2, destination processor ID width.
REQ-003 SHALL have parameter LEN_W, default 8, packet length field width; DATA_W >= LEN_W is required.
REQ-004 SHALL have port clock  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  testbench/host packet request.
REQ-007 SHALL have port dest  input  DEST_W  target processor ID, sampled with start.
REQ-008 SHALL have port len  input  LEN_W  index of last flit (packet = len+1 flits), sampled with start.
REQ-009 SHALL have port master_grant  input  1  router grant for the pending request.
REQ-010 SHALL have port request_transfer  output  1  request to router, registered.
REQ-011 SHALL have port which_processor  output  DEST_W  latched destination ID.
REQ-012 SHALL have port processor_ready  output  1  high only in IDLE.
REQ-013 SHALL have port tx_data  output  DATA_W+1  {last, payload} flit to router.
REQ-014 SHALL have port tx_valid  output  1  tx_data valid.
REQ-015 SHALL have port tx_ready  input  1  router accepts flit when tx_valid & tx_ready.
REQ-016 SHALL have port pkt_done  output  1  one-cycle pulse after last flit accepted.
REQ-017 SHALL have port rx_data  input  DATA_W+1  {last, payload} flit from router.
REQ-018 SHALL have port rx_valid  input  1  rx_data valid.
REQ-019 SHALL have port err_count  output  8  received-flit mismatch count.

Function
REQ-020 SHALL implement FSM IDLE, REQ, SEND; all outputs registered.
REQ-021 IDLE: start=1 SHALL latch dest/len, zero flit index, set request_transfer=1, enter REQ next edge.
REQ-022 start in REQ or SEND SHALL be ignored; dest/len changes after latch SHALL not affect the packet.
REQ-023 REQ: master_grant=1 SHALL clear request_transfer and enter SEND next edge; request_transfer holds until grant.
REQ-024 SEND: tx_valid=1; tx_data payload = flit index zero-extended to DATA_W; last = (index == latched len).
REQ-025 Index SHALL increment only on tx_valid & tx_ready; tx_data SHALL hold stable while tx_ready=0.
REQ-026 Accept of last flit SHALL return FSM to IDLE, drop tx_valid, pulse pkt_done for exactly one cycle the next cycle.
REQ-027 len=0 SHALL send exactly one flit with last=1; len=2^LEN_W-1 SHALL send 2^LEN_W flits without index wrap.
REQ-028 Minimum start-to-first-flit latency SHALL be 2 cycles with master_grant already high.
REQ-029 start may be accepted on the cycle after pkt_done (IDLE again).

Reset
REQ-030 Reset SHALL force IDLE, request_transfer=0, which_processor=0, processor_ready=1, tx_data=0, tx_valid=0, pkt_done=0, err_count=0, index=0.
REQ-031 Reset asserted mid-packet SHALL abort immediately with no pkt_done; no partial state survives.

Configuration
REQ-032 Macro PE_RX_CHECK_EN defined: receive checker SHALL compare each rx_valid flit payload to expected index (starting 0, +1 per flit, back to 0 after a flit with last=1).
REQ-033 With PE_RX_CHECK_EN: each mismatch SHALL increment err_count, saturating at 255; expected index SHALL resync to received payload+1.
REQ-034 Without PE_RX_CHECK_EN: rx_data/rx_valid SHALL be ignored, err_count tied to 0, no checker logic.

Verification
REQ-035 dest=2, len=3, start pulse, grant next cycle, tx_ready=1 -> which_processor=2, flits 0x000,0x001,0x002,0x103 (DATA_W=8), one pkt_done.
REQ-036 len=0 -> single flit 0x100, pkt_done next cycle, processor_ready back to 1.
REQ-037 grant delayed 5 cycles, tx_ready toggled 1/0 -> request_transfer high 5+ cycles, no flit lost or duplicated, tx_data stable when stalled.
REQ-038 reset at 2nd flit of len=5 packet -> all outputs at reset values, no pkt_done, next start behaves normally.
REQ-039 PE_RX_CHECK_EN, rx payloads 0,1,3,4(last) -> err_count=1; 300 mismatches -> err_count=255.

Source files
------------

// File: rtl/pe_traffic_gen.sv
// pe_traffic_gen: processing-element traffic generator.
//   On a host start pulse it latches a destination and length, requests the
//   router, and once granted streams len+1 flits whose payload is the flit
//   index and whose MSB marks the last flit. pkt_done pulses once after the
//   last flit is accepted.
//
// Optional feature: define PE_RX_CHECK_EN to build a receive checker that
//   counts received flits whose payload differs from the expected running
//   index (saturating at 255). Without it rx_* are ignored and err_count = 0.
//
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   start, dest, len        host request; dest/len sampled with start in IDLE
//   master_grant            router grant for the pending request
//   request_transfer        registered request to the router
//   which_processor         latched destination ID
//   processor_ready         high only while idle
//   tx_data/valid/ready     {last, payload} flit stream to the router
//   pkt_done                one-cycle pulse after the last flit is accepted
//   rx_data/valid           {last, payload} flit stream from the router
//   err_count               received-flit mismatch count
module pe_traffic_gen #(
  parameter int DATA_W = 8,
  parameter int DEST_W = 2,
  parameter int LEN_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DEST_W-1:0] dest,
  input  logic [LEN_W-1:0]  len,
  input  logic              master_grant,
  output logic              request_transfer,
  output logic [DEST_W-1:0] which_processor,
  output logic              processor_ready,
  output logic [DATA_W:0]   tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              pkt_done,
  input  logic [DATA_W:0]   rx_data,
  input  logic              rx_valid,
  output logic [7:0]        err_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SEND = 2'd2} state_t;

  state_t state, state_nx;

  logic [LEN_W-1:0]  len_q, idx, len_nx, idx_nx;
  logic [DEST_W-1:0] which_nx;
  logic [DATA_W:0]   data_nx;
  logic              req_nx, ready_nx, valid_nx, done_nx;

  logic accept, last_acc;
  assign accept   = tx_valid & tx_ready;
  assign last_acc = accept && (idx == len_q);

  // Flit image for index i: MSB flags the last flit, payload is i zero-extended.
  function automatic logic [DATA_W:0] flit(input logic [LEN_W-1:0] i,
                                           input logic [LEN_W-1:0] l);
    return {(i == l), DATA_W'(i)};
  endfunction

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      len_q            <= '0;
      idx              <= '0;
      request_transfer <= 1'b0;
      which_processor  <= '0;
      processor_ready  <= 1'b1;
      tx_data          <= '0;
      tx_valid         <= 1'b0;
      pkt_done         <= 1'b0;
    end else begin
      state            <= state_nx;
      len_q            <= len_nx;
      idx              <= idx_nx;
      request_transfer <= req_nx;
      which_processor  <= which_nx;
      processor_ready  <= ready_nx;
      tx_data          <= data_nx;
      tx_valid         <= valid_nx;
      pkt_done         <= done_nx;
    end
  end

  // Next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)        state_nx = REQ;
      REQ:     if (master_grant) state_nx = SEND;
      SEND:    if (last_acc)     state_nx = IDLE;
      default:                   state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    len_nx   = len_q;
    idx_nx   = idx;
    which_nx = which_processor;
    req_nx   = request_transfer;
    valid_nx = tx_valid;
    data_nx  = tx_data;
    done_nx  = 1'b0;
    ready_nx = (state_nx == IDLE);
    case (state)
      IDLE: if (start) begin
        len_nx   = len;
        idx_nx   = '0;
        which_nx = dest;
        req_nx   = 1'b1;
      end
      REQ: if (master_grant) begin
        req_nx   = 1'b0;
        valid_nx = 1'b1;
        data_nx  = flit(idx, len_q);
      end
      SEND: if (accept) begin
        if (idx == len_q) begin
          valid_nx = 1'b0;
          done_nx  = 1'b1;
        end else begin
          // idx < len_q here, so the increment cannot wrap
          idx_nx  = idx + 1'b1;
          data_nx = flit(idx + 1'b1, len_q);
        end
      end
      default: ;
    endcase
  end

`ifdef PE_RX_CHECK_EN
  logic [DATA_W-1:0] rx_exp;
  logic [DATA_W-1:0] rx_pay;
  assign rx_pay = rx_data[DATA_W-1:0];

  // A mismatch resyncs to the received payload; a last flit always restarts at 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_exp    <= '0;
      err_count <= '0;
    end else if (rx_valid) begin
      if (rx_pay != rx_exp && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (rx_data[DATA_W])       rx_exp <= '0;
      else if (rx_pay != rx_exp) rx_exp <= rx_pay + 1'b1;
      else                       rx_exp <= rx_exp + 1'b1;
    end
  end
`else
  logic unused_rx;
  assign unused_rx = ^{rx_data, rx_valid};
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_pe_traffic_gen.sv
module tb_pe_traffic_gen;
  localparam int DATA_W = 8;
  localparam int DEST_W = 2;
  localparam int LEN_W  = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [DEST_W-1:0] dest = '0;
  logic [LEN_W-1:0]  len = '0;
  logic              master_grant = 1'b0;
  logic              request_transfer;
  logic [DEST_W-1:0] which_processor;
  logic              processor_ready;
  logic [DATA_W:0]   tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b0;
  logic              pkt_done;
  logic [DATA_W:0]   rx_data = '0;
  logic              rx_valid = 1'b0;
  logic [7:0]        err_count;

  int tests = 0;
  int fails = 0;

  pe_traffic_gen #(.DATA_W(DATA_W), .DEST_W(DEST_W), .LEN_W(LEN_W)) dut (
    .clock(clock), .reset(reset), .start(start), .dest(dest), .len(len),
    .master_grant(master_grant), .request_transfer(request_transfer),
    .which_processor(which_processor), .processor_ready(processor_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .pkt_done(pkt_done), .rx_data(rx_data), .rx_valid(rx_valid),
    .err_count(err_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A packet is: waiting for grant, then a queue of flits still to be accepted.
  bit                m_pend = 0;
  bit                m_send = 0;
  bit                m_done = 0;
  logic [DEST_W-1:0] m_which = '0;
  logic [DATA_W:0]   m_q[$];
  logic [7:0]        m_err = '0;
  int                m_rxexp = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_pend = 0; m_send = 0; m_done = 0; m_which = '0; m_q.delete();
      m_err = '0; m_rxexp = 0;
    end else begin
      m_done = 0;
      if (m_send) begin
        if (tx_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin m_send = 0; m_done = 1; end
        end
      end else if (m_pend) begin
        if (master_grant) begin m_pend = 0; m_send = 1; end
      end else if (start) begin
        m_pend  = 1;
        m_which = dest;
        for (int i = 0; i <= int'(len); i++)
          m_q.push_back({(i == int'(len)), DATA_W'(i)});
      end
`ifdef PE_RX_CHECK_EN
      if (rx_valid) begin
        int p;
        p = int'(rx_data[DATA_W-1:0]);
        if (p != m_rxexp) begin
          if (m_err < 255) m_err = m_err + 8'd1;
          m_rxexp = (p + 1) % (1 << DATA_W);
        end else m_rxexp = (m_rxexp + 1) % (1 << DATA_W);
        if (rx_data[DATA_W]) m_rxexp = 0;
      end
`endif
    end
  end

  // ---------------- compare process ----------------
  logic [DATA_W:0] obs[$];
  int done_cnt = 0;
  int req_hi = 0;

  always @(negedge clock) begin
    chk("request_transfer", request_transfer, m_pend);
    chk("tx_valid", tx_valid, m_send);
    chk("processor_ready", processor_ready, !m_pend && !m_send);
    chk("pkt_done", pkt_done, m_done);
    chk("which_processor", which_processor, m_which);
    chk("err_count", err_count, m_err);
    if (m_send && m_q.size() > 0) chk("tx_data", tx_data, m_q[0]);
    if (tx_valid && tx_ready) obs.push_back(tx_data);
    if (pkt_done) done_cnt++;
    if (request_transfer) req_hi++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock); #2;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (!processor_ready && n < lim) begin tick(); n++; end
    tests++;
    if (!processor_ready) begin
      fails++;
      $display("FAIL wait_idle: processor_ready still low after %0d cycles", lim);
    end
    tick();
  endtask

  task automatic send_pkt(input logic [DEST_W-1:0] d, input logic [LEN_W-1:0] l);
    dest = d; len = l; start = 1; tick(); start = 0;
  endtask

  task automatic chk_flits(input string name, input int l);
    chk({name, "_count"}, obs.size(), l + 1);
    for (int i = 0; i <= l && i < obs.size(); i++)
      chk(name, obs[i], {(i == l), DATA_W'(i)});
  endtask

  initial begin
    // reset state
    repeat (3) tick();
    chk("rst_ready", processor_ready, 1);
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_err", err_count, 0);
    reset = 0; tick();

    // dest=2 len=3, grant the cycle after start, 2-cycle latency to first flit
    obs.delete(); done_cnt = 0; tx_ready = 1;
    send_pkt(2, 3); master_grant = 1; dest = 1; len = 9; tick();
    chk("latency_valid", tx_valid, 1);
    chk("latency_data", tx_data, 9'h000);
    wait_idle(50);
    chk("f0", obs[0], 9'h000); chk("f1", obs[1], 9'h001);
    chk("f2", obs[2], 9'h002); chk("f3", obs[3], 9'h103);
    chk("which2", which_processor, 2);
    chk("done_once", done_cnt, 1);

    // len=0: single last flit
    obs.delete(); done_cnt = 0;
    send_pkt(1, 0); wait_idle(50);
    chk("len0_count", obs.size(), 1);
    chk("len0_flit", obs[0], 9'h100);
    chk("len0_done", done_cnt, 1);
    chk("len0_ready", processor_ready, 1);

    // grant held off 5 cycles, tx_ready toggling
    obs.delete(); done_cnt = 0; req_hi = 0; master_grant = 0;
    send_pkt(3, 4);
    repeat (5) tick();
    master_grant = 1;
    for (int n = 0; n < 60 && !processor_ready; n++) begin
      tx_ready = ~tx_ready; tick();
    end
    tx_ready = 1; wait_idle(20);
    tests++;
    if (req_hi < 5) begin fails++; $display("FAIL req_hold: got %0d cycles expected >= 5", req_hi); end
    chk_flits("stall_flits", 4);
    chk("stall_done", done_cnt, 1);

    // reset while the 2nd flit of a len=5 packet is presented
    obs.delete(); done_cnt = 0;
    send_pkt(2, 5); tick(); tick();
    chk("mid_flit1", tx_data, 9'h001);
    reset = 1; #1;
    chk("mr_req", request_transfer, 0); chk("mr_which", which_processor, 0);
    chk("mr_ready", processor_ready, 1); chk("mr_data", tx_data, 0);
    chk("mr_valid", tx_valid, 0); chk("mr_done", pkt_done, 0);
    tick(); reset = 0; tick();
    chk("mr_no_done", done_cnt, 0);
    obs.delete();
    send_pkt(1, 2); wait_idle(50);
    chk_flits("after_rst", 2);
    chk("after_rst_done", done_cnt, 1);

    // longest packet: 256 flits without wrap
    obs.delete();
    send_pkt(0, 8'hFF);
    for (int n = 0; n < 2000 && !processor_ready; n++) begin
      tx_ready = ($urandom_range(0, 3) != 0); tick();
    end
    tx_ready = 1; wait_idle(10);
    chk("long_count", obs.size(), 256);
    chk("long_last", obs[255], 9'h1FF);

    // randomized traffic, start/dest/len churning also while busy
    for (int n = 0; n < 3000; n++) begin
      start        = ($urandom_range(0, 3) == 0);
      dest         = DEST_W'($urandom);
      len          = LEN_W'($urandom_range(0, 7));
      master_grant = ($urandom_range(0, 1) == 1);
      tx_ready     = ($urandom_range(0, 4) != 0);
      rx_valid     = ($urandom_range(0, 1) == 1);
      rx_data      = {($urandom_range(0, 3) == 0), DATA_W'($urandom_range(0, 3))};
      tick();
    end
    start = 0; rx_valid = 0; master_grant = 1; tx_ready = 1;
    wait_idle(50);

`ifdef PE_RX_CHECK_EN
    reset = 1; tick(); reset = 0; tick();
    rx_valid = 1;
    rx_data = 9'h000; tick();
    rx_data = 9'h001; tick();
    rx_data = 9'h003; tick();
    rx_data = 9'h104; tick();
    rx_valid = 0;
    chk("rx_err1", err_count, 1);
    rx_valid = 1; rx_data = 9'h005;
    repeat (300) tick();
    rx_valid = 0;
    chk("rx_sat", err_count, 255);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
